zigbee_mux_bank: RTL and testbench

Bank of three independent selectors used in the ZigBee datapath: a 2:1 single-bit mux, a 4:1 mux of 4-bit nibbles, and an 8:1 single-bit mux. Each selector drives a combinational output for zero-latency paths and a registered copy for timing-closed paths. All three share one clock and a synchronous reset. The selectors have no interaction with each other.

---
 rtl/zigbee_mux_bank.sv | 136 +++++++++++++
 tb/tb_zigbee_mux_bank.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/zigbee_mux_bank.sv
// -----------------------------------------------------------------------------
// zigbee_mux_bank
//
// Purpose:
//   Three independent selectors for the ZigBee datapath. Each one has a
//   combinational result for zero-latency consumers and a registered copy
//   for timing-closed consumers:
//     - 2:1 mux of single bits
//     - 4:1 mux of 4-bit nibbles
//     - 8:1 mux of single bits
//   The selectors share the clock and the reset and nothing else.
//
// Ports:
//   clk           in   1   rising-edge clock for the registered outputs
//   rst           in   1   synchronous active-high reset, clears all *_q
//   inData211     in   2   2:1 data, bit i chosen by inSel211 = i
//   inSel211      in   1   2:1 select
//   outData211    out  1   combinational 2:1 result
//   outData211_q  out  1   registered 2:1 result
//   inData414     in  16   four nibbles, nibble i = inData414[4i+3:4i]
//   inSel414      in   2   4:1 nibble select
//   outData414    out  4   combinational nibble result
//   outData414_q  out  4   registered nibble result
//   inData811     in   8   8:1 data, bit i chosen by inSel811 = i
//   inSel811      in   3   8:1 select
//   outData811    out  1   combinational 8:1 result
//   outData811_q  out  1   registered 8:1 result
// -----------------------------------------------------------------------------
module zigbee_mux_bank (
    input  logic        clk,
    input  logic        rst,

    input  logic [1:0]  inData211,
    input  logic        inSel211,
    output logic        outData211,
    output logic        outData211_q,

    input  logic [15:0] inData414,
    input  logic [1:0]  inSel414,
    output logic [3:0]  outData414,
    output logic [3:0]  outData414_q,

    input  logic [7:0]  inData811,
    input  logic [2:0]  inSel811,
    output logic        outData811,
    output logic        outData811_q
);

    // -------------------------------------------------------------------------
    // Next-state values; these are also the combinational outputs.
    // -------------------------------------------------------------------------
    logic       out211_d;
    logic [3:0] out414_d;
    logic       out811_d;

    logic       out211_q;
    logic [3:0] out414_q;
    logic       out811_q;

    // Split the 16-bit bus into an array of nibbles so the 4:1 select reads
    // as a plain index into named lanes.
    logic [3:0] nibble [4];

    for (genvar gi = 0; gi < 4; gi++) begin : g_nibble
        assign nibble[gi] = inData414[4*gi +: 4];
    end

    // -------------------------------------------------------------------------
    // 2:1 selector. The default arm makes an unknown select resolve to 0
    // instead of propagating X into the datapath.
    // -------------------------------------------------------------------------
    always_comb begin
        out211_d = 1'b0;
        case (inSel211)
            1'b0:    out211_d = inData211[0];
            1'b1:    out211_d = inData211[1];
            default: out211_d = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // 4:1 nibble selector.
    // -------------------------------------------------------------------------
    always_comb begin
        out414_d = 4'h0;
        case (inSel414)
            2'd0:    out414_d = nibble[0];
            2'd1:    out414_d = nibble[1];
            2'd2:    out414_d = nibble[2];
            2'd3:    out414_d = nibble[3];
            default: out414_d = 4'h0;
        endcase
    end

    // -------------------------------------------------------------------------
    // 8:1 selector; bit index equals the unsigned select value.
    // -------------------------------------------------------------------------
    always_comb begin
        out811_d = 1'b0;
        case (inSel811)
            3'd0:    out811_d = inData811[0];
            3'd1:    out811_d = inData811[1];
            3'd2:    out811_d = inData811[2];
            3'd3:    out811_d = inData811[3];
            3'd4:    out811_d = inData811[4];
            3'd5:    out811_d = inData811[5];
            3'd6:    out811_d = inData811[6];
            3'd7:    out811_d = inData811[7];
            default: out811_d = 1'b0;
        endcase
    end

    // -------------------------------------------------------------------------
    // Registered copies. Reset has priority over capture.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            out211_q <= 1'b0;
            out414_q <= 4'h0;
            out811_q <= 1'b0;
        end else begin
            out211_q <= out211_d;
            out414_q <= out414_d;
            out811_q <= out811_d;
        end
    end

    assign outData211   = out211_d;
    assign outData414   = out414_d;
    assign outData811   = out811_d;

    assign outData211_q = out211_q;
    assign outData414_q = out414_q;
    assign outData811_q = out811_q;

endmodule

// File: tb/tb_zigbee_mux_bank.sv
// -----------------------------------------------------------------------------
// tb_zigbee_mux_bank
//
// Self-checking bench for zigbee_mux_bank: a table of directed vectors for
// the combinational paths, an exhaustive 8:1 sweep, hand-written sequences
// for the registered/reset/independence behaviour and a randomized run
// checked against a shift-and-mask reference model.
// -----------------------------------------------------------------------------
module tb_zigbee_mux_bank;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  inData211;
    logic        inSel211;
    logic        outData211;
    logic        outData211_q;
    logic [15:0] inData414;
    logic [1:0]  inSel414;
    logic [3:0]  outData414;
    logic [3:0]  outData414_q;
    logic [7:0]  inData811;
    logic [2:0]  inSel811;
    logic        outData811;
    logic        outData811_q;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    zigbee_mux_bank dut (
        .clk          (clk),
        .rst          (rst),
        .inData211    (inData211),
        .inSel211     (inSel211),
        .outData211   (outData211),
        .outData211_q (outData211_q),
        .inData414    (inData414),
        .inSel414     (inSel414),
        .outData414   (outData414),
        .outData414_q (outData414_q),
        .inData811    (inData811),
        .inSel811     (inSel811),
        .outData811   (outData811),
        .outData811_q (outData811_q)
    );

    // Directed vector record: inputs plus expected combinational outputs.
    typedef struct {
        logic [1:0]  d211;
        logic        s211;
        logic [15:0] d414;
        logic [1:0]  s414;
        logic [7:0]  d811;
        logic [2:0]  s811;
        logic        e211;
        logic [3:0]  e414;
        logic        e811;
    } vec_t;

    localparam int NVEC = 14;
    vec_t vecs [NVEC];

    function automatic vec_t mk(logic [1:0] d211, logic s211, logic [15:0] d414,
                                logic [1:0] s414, logic [7:0] d811, logic [2:0] s811,
                                logic e211, logic [3:0] e414, logic e811);
        vec_t v;
        v.d211 = d211; v.s211 = s211; v.d414 = d414; v.s414 = s414;
        v.d811 = d811; v.s811 = s811;
        v.e211 = e211; v.e414 = e414; v.e811 = e811;
        return v;
    endfunction

    // Reference model: select by shifting the bus right by (select * width)
    // and masking.
    function automatic logic m211(logic [1:0] d, logic s);
        return 1'(int'(d) >> int'(s));
    endfunction
    function automatic logic [3:0] m414(logic [15:0] d, logic [1:0] s);
        return 4'((int'(d) >> (4 * int'(s))) & 15);
    endfunction
    function automatic logic m811(logic [7:0] d, logic [2:0] s);
        return 1'((int'(d) >> int'(s)) & 1);
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] d211, input logic s211, input logic [15:0] d414,
                         input logic [1:0] s414, input logic [7:0] d811, input logic [2:0] s811);
        inData211 = d211; inSel211 = s211;
        inData414 = d414; inSel414 = s414;
        inData811 = d811; inSel811 = s811;
    endtask

    initial begin
        logic       exp211_q;
        logic [3:0] exp414_q;
        logic       exp811_q;
        logic       hold211;
        logic [3:0] hold414;

        // ---------------- directed table ----------------
        // 2:1 exhaustive, sel 0 then sel 1
        vecs[0]  = mk(2'b00, 1'b0, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b0, 4'h0, 1'b0);
        vecs[1]  = mk(2'b01, 1'b0, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b1, 4'h0, 1'b0);
        vecs[2]  = mk(2'b10, 1'b0, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b0, 4'h0, 1'b0);
        vecs[3]  = mk(2'b11, 1'b0, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b1, 4'h0, 1'b0);
        vecs[4]  = mk(2'b00, 1'b1, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b0, 4'h0, 1'b0);
        vecs[5]  = mk(2'b01, 1'b1, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b0, 4'h0, 1'b0);
        vecs[6]  = mk(2'b10, 1'b1, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b1, 4'h0, 1'b0);
        vecs[7]  = mk(2'b11, 1'b1, 16'h0000, 2'd0, 8'h00, 3'd0, 1'b1, 4'h0, 1'b0);
        // 4:1 nibble walk
        vecs[8]  = mk(2'b00, 1'b0, 16'h0030, 2'd1, 8'h00, 3'd0, 1'b0, 4'h3, 1'b0);
        vecs[9]  = mk(2'b00, 1'b0, 16'hA000, 2'd3, 8'h00, 3'd0, 1'b0, 4'hA, 1'b0);
        vecs[10] = mk(2'b00, 1'b0, 16'h0A00, 2'd0, 8'h00, 3'd0, 1'b0, 4'h0, 1'b0);
        // 8:1 bit walk
        vecs[11] = mk(2'b00, 1'b0, 16'h0000, 2'd0, 8'h04, 3'd2, 1'b0, 4'h0, 1'b1);
        vecs[12] = mk(2'b00, 1'b0, 16'h0000, 2'd0, 8'h04, 3'd3, 1'b0, 4'h0, 1'b0);
        vecs[13] = mk(2'b00, 1'b0, 16'h0000, 2'd0, 8'h80, 3'd7, 1'b0, 4'h0, 1'b1);

        // ---------------- reset state ----------------
        rst = 1'b1;
        drive(2'b00, 1'b0, 16'h0000, 2'd0, 8'h00, 3'd0);
        repeat (2) @(posedge clk);
        #1;
        chk("reset_q211", 16'(outData211_q), 16'h0);
        chk("reset_q414", 16'(outData414_q), 16'h0);
        chk("reset_q811", 16'(outData811_q), 16'h0);
        $display("[TB] reset: q211=%0h q414=%0h q811=%0h", outData211_q, outData414_q, outData811_q);

        // Combinational outputs stay live while reset is held.
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].d211, vecs[i].s211, vecs[i].d414, vecs[i].s414, vecs[i].d811, vecs[i].s811);
            #1;
            chk($sformatf("vec%0d_o211", i), 16'(outData211), 16'(vecs[i].e211));
            chk($sformatf("vec%0d_o414", i), 16'(outData414), 16'(vecs[i].e414));
            chk($sformatf("vec%0d_o811", i), 16'(outData811), 16'(vecs[i].e811));
            $display("[TB] vec %0d: 211 %0h/%0h 414 %0h/%0h 811 %0h/%0h", i,
                     inData211, inSel211, inData414, inSel414, inData811, inSel811);
        end

        // 8:1 sweep: every select against 00..0F and 10..F0.
        for (int d = 0; d < 31; d++) begin
            logic [7:0] dv;
            dv = (d < 16) ? 8'(d) : 8'((d - 15) << 4);
            for (int s = 0; s < 8; s++) begin
                inData811 = dv;
                inSel811  = 3'(s);
                #1;
                chk($sformatf("sweep811_d%0h_s%0d", dv, s), 16'(outData811), 16'(dv[s]));
            end
        end
        $display("[TB] 8:1 sweep done");

        // ---------------- registered path ----------------
        @(negedge clk);
        drive(2'b00, 1'b0, 16'h0000, 2'd0, 8'h00, 3'd0);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("regpath_q414_pre", 16'(outData414_q), 16'h0);
        @(negedge clk);
        inSel414  = 2'd2;
        inData414 = 16'h0500;
        #1;
        chk("regpath_o414", 16'(outData414), 16'h5);
        chk("regpath_q414_hold", 16'(outData414_q), 16'h0);
        @(posedge clk); #1;
        chk("regpath_q414_after", 16'(outData414_q), 16'h5);
        $display("[TB] regpath: o414=%0h q414=%0h", outData414, outData414_q);

        // ---------------- reset priority ----------------
        @(negedge clk);
        rst       = 1'b1;
        inData211 = 2'b10;
        inSel211  = 1'b1;
        #1;
        chk("rstprio_o211", 16'(outData211), 16'h1);
        @(posedge clk); #1;
        chk("rstprio_q211", 16'(outData211_q), 16'h0);
        chk("rstprio_q414", 16'(outData414_q), 16'h0);
        @(posedge clk); #1;
        chk("rstprio_q211_held", 16'(outData211_q), 16'h0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("rstprio_q211_release", 16'(outData211_q), 16'h1);
        $display("[TB] rstprio: o211=%0h q211=%0h", outData211, outData211_q);

        // ---------------- independence ----------------
        @(negedge clk);
        drive(2'b01, 1'b0, 16'h9C3E, 2'd1, 8'hA5, 3'd0);
        @(posedge clk); #1;
        hold211 = m211(2'b01, 1'b0);
        hold414 = m414(16'h9C3E, 2'd1);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            inSel811 = 3'((c * 5 + 3) % 8);
            #1;
            chk($sformatf("indep%0d_o811", c), 16'(outData811), 16'(m811(8'hA5, inSel811)));
            chk($sformatf("indep%0d_o211", c), 16'(outData211), 16'(hold211));
            chk($sformatf("indep%0d_o414", c), 16'(outData414), 16'(hold414));
            @(posedge clk); #1;
            chk($sformatf("indep%0d_q811", c), 16'(outData811_q), 16'(m811(8'hA5, inSel811)));
            chk($sformatf("indep%0d_q211", c), 16'(outData211_q), 16'(hold211));
            chk($sformatf("indep%0d_q414", c), 16'(outData414_q), 16'(hold414));
            $display("[TB] indep %0d: sel811=%0d o811=%0h", c, inSel811, outData811);
        end

        // ---------------- randomized run vs model ----------------
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 7) == 0);
            drive(2'($urandom), 1'($urandom), 16'($urandom), 2'($urandom),
                  8'($urandom), 3'($urandom));
            #1;
            chk($sformatf("rnd%0d_o211", t), 16'(outData211), 16'(m211(inData211, inSel211)));
            chk($sformatf("rnd%0d_o414", t), 16'(outData414), 16'(m414(inData414, inSel414)));
            chk($sformatf("rnd%0d_o811", t), 16'(outData811), 16'(m811(inData811, inSel811)));
            exp211_q = rst ? 1'b0 : m211(inData211, inSel211);
            exp414_q = rst ? 4'h0 : m414(inData414, inSel414);
            exp811_q = rst ? 1'b0 : m811(inData811, inSel811);
            @(posedge clk); #1;
            chk($sformatf("rnd%0d_q211", t), 16'(outData211_q), 16'(exp211_q));
            chk($sformatf("rnd%0d_q414", t), 16'(outData414_q), 16'(exp414_q));
            chk($sformatf("rnd%0d_q811", t), 16'(outData811_q), 16'(exp811_q));
            $display("[TB] rnd %0d: rst=%0d 211 %0h/%0h 414 %0h/%0h 811 %0h/%0h", t, rst,
                     inData211, inSel211, inData414, inSel414, inData811, inSel811);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
